ahb_burst_master: RTL and testbench
===================================

Name: ahb_burst_master

Overview:
AHB-Lite initiator that turns simple command/stream requests into single or incrementing-burst word transfers. It drives the slave-side bus: HSEL decode is external, and the block connects upstream of the address decoder and slaves such as SRAM. Local logic issues one command; the block streams write data in, or read data out, and reports completion and error status.

Parameters:
MAX_BEATS, 16, largest burst length accepted; cmd_len values above this are clamped to MAX_BEATS.
LEN_W, 5, width of cmd_len; must hold MAX_BEATS.

Ports:
HCLK  input  1  bus clock; all logic is on posedge.
HRESETn  input  1  asynchronous active-low reset.
cmd_valid  input  1  command request.
cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
cmd_write  input  1  1 = write, 0 = read.
cmd_addr  input  32  start byte address; bits [1:0] are ignored and forced to 0.
cmd_len  input  LEN_W  beat count; 0 is treated as 1.
wr_valid  input  1  write data available.
wr_ready  output  1  pulses for one cycle when the current wr_data is consumed, i.e. at its address phase.
wr_data  input  32  write word.
rd_valid  output  1  one-cycle pulse per completed read beat; there is no backpressure.
rd_data  output  32  read word, valid while rd_valid is high.
done  output  1  one-cycle pulse when a command ends.
err  output  1  valid with done; 1 = the command was aborted by an ERROR response.
HADDR  output  32  address.
HTRANS  output  2  transfer type: IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
HWRITE  output  1  transfer direction.
HSIZE  output  3  fixed at 010 (word).
HBURST  output  3  000 SINGLE when len=1; 011/101/111 INCR4/8/16 when len is exactly 4/8/16; otherwise 001 INCR.
HWDATA  output  32  write data for the current data phase.
HREADY  input  1  bus ready.
HRESP  input  2  00 OKAY, 01 ERROR.
HRDATA  input  32  read data.

Behaviour:
- Reset values: cmd_ready=1; wr_ready, rd_valid, done, err=0; HTRANS=00; HADDR, HWDATA, HBURST, HWRITE=0; HSIZE=010.
- An asserted reset aborts any command immediately and returns the block to IDLE. No done pulse is generated.
- The address and control outputs hold their values whenever HREADY=0.
- Pipelining: the data phase of beat n overlaps the address phase of beat n+1. The address phase advances only on a cycle with HREADY=1.
- States:
  - IDLE: drive HTRANS=IDLE. On command accept, latch addr, len and dir, and go to ADDR.
  - ADDR: first address phase with NONSEQ.
    - For a write, wait in ADDR with HTRANS=IDLE until wr_valid is high.
  - BURST: each following beat uses SEQ, with HADDR incremented by 4.
    - For writes with wr_valid low mid-burst: drive BUSY and hold HADDR.
    - On the cycle wr_valid returns: resume with SEQ.
    - HWDATA is registered from the word consumed in the previous address phase.
  - LAST: after the final address phase is accepted, drive IDLE and wait for the final data phase with HREADY=1.
    - Then pulse done with err=0 and return to IDLE.
  - ERR: on any data phase where HRESP=01 and HREADY=0 (first error cycle), drive HTRANS=IDLE in that same cycle, cancelling the pending address.
    - On the second error cycle (HREADY=1), pulse done with err=1 and return to IDLE.
    - Remaining beats are dropped and no further wr_ready is issued.
- 1 KB boundary: if the next beat address has [9:0]=0, that beat is issued as NONSEQ with HBURST=INCR. INCRn bursts are downgraded to INCR for the whole command when cmd_addr+4*len crosses 1 KB.
- rd_valid asserts in the cycle after a read data phase completes with HREADY=1 and HRESP=OKAY. rd_data is registered from HRDATA.
- Minimum command latency: accept cycle, then the address phase, then the data phase. done appears 3 cycles after accept for a zero-wait single transfer.
- A command is not accepted in the same cycle as done; cmd_ready returns the cycle after done.

Optional Feature:
AHB_MST_BSWAP_EN: when defined, wr_data is byte-reversed before HWDATA ([7:0]<->[31:24], [15:8]<->[23:16]), and HRDATA is byte-reversed before rd_data. This matches big-endian lane order on local memories. When undefined, data passes straight through.

Test Plan:
1. Write single, addr 0x100, data 0xA1B2C3D4, zero wait:
   - NONSEQ/SINGLE/HWRITE=1 at 0x100.
   - HWDATA=0xA1B2C3D4 the next cycle.
   - done=1, err=0 three cycles after accept.
2. Read INCR4 at 0x200, slave returns 1,2,3,4 with one wait state on beat 2:
   - HADDR 0x200/204/208/20C, HTRANS NONSEQ,SEQ,SEQ,SEQ, HBURST=011.
   - Address held during the wait state.
   - rd_valid pulses 4 times with data 1..4, then done.
3. Write len=3 with wr_valid low for 2 cycles before beat 2:
   - HTRANS shows BUSY,BUSY then SEQ, with HADDR held at 0x304.
   - Exactly 3 wr_ready pulses.
4. Read len=4 at 0x3F8:
   - HBURST=INCR.
   - Beat at 0x400 issued as NONSEQ.
5. ERROR on beat 2 of a 5-beat write:
   - HTRANS=IDLE in the first error cycle.
   - No beats 3–5 issued.
   - done=1, err=1 after the second error cycle.
   - wr_ready pulsed only 3 times.
6. Reset asserted mid-burst:
   - All outputs return to their reset values asynchronously.
   - After release, a new command at 0x0 completes normally.
   - With AHB_MST_BSWAP_EN, wr_data 0x11223344 appears on HWDATA as 0x44332211.

Source files
------------

// File: rtl/ahb_burst_master_if.sv
// ahb_burst_master_if: local command/stream side plus AHB-Lite initiator bus of ahb_burst_master
//   master modport: the initiator (drives cmd_ready, wr_ready, rd_*, done, err, HADDR..HWDATA)
//   slave modport : local logic plus the bus fabric (drives cmd_*, wr_valid, wr_data, HREADY, HRESP, HRDATA)
interface ahb_burst_master_if #(parameter int LEN_W = 5);
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_write;
   logic [31:0]      cmd_addr;
   logic [LEN_W-1:0] cmd_len;
   logic             wr_valid;
   logic             wr_ready;
   logic [31:0]      wr_data;
   logic             rd_valid;
   logic [31:0]      rd_data;
   logic             done;
   logic             err;
   logic [31:0]      HADDR;
   logic [1:0]       HTRANS;
   logic             HWRITE;
   logic [2:0]       HSIZE;
   logic [2:0]       HBURST;
   logic [31:0]      HWDATA;
   logic             HREADY;
   logic [1:0]       HRESP;
   logic [31:0]      HRDATA;
   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, HREADY, HRESP, HRDATA,
      output cmd_ready, wr_ready, rd_valid, rd_data, done, err, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
   );
   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, HREADY, HRESP, HRDATA,
      input  cmd_ready, wr_ready, rd_valid, rd_data, done, err, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
   );
endinterface

// File: rtl/ahb_burst_master.sv
// ahb_burst_master: AHB-Lite initiator turning one command into a SINGLE or INCR/INCRn word burst
//   HCLK, HRESETn : bus clock, asynchronous active-low reset
//   bus (master)  : cmd_* command handshake, wr_* write stream, rd_* read stream, done/err status,
//                   AHB-Lite HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA out, HREADY/HRESP/HRDATA in
//   AHB_MST_BSWAP_EN : when defined, write and read words are byte-reversed between local side and bus
module ahb_burst_master #(
   parameter int MAX_BEATS = 16,
   parameter int LEN_W     = 5
) (
   input logic                HCLK,
   input logic                HRESETn,
   ahb_burst_master_if.master bus
);
   localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERR, S_DONE} state_t;
   state_t           r_state, w_nxt;
   logic [31:0]      r_addr;
   logic [LEN_W-1:0] r_left;
   logic             r_write;
   logic [2:0]       r_burst;
   logic             r_dph;
   logic [31:0]      r_hwdata;
   logic             r_rd_valid;
   logic [31:0]      r_rd_data;
   logic             r_err;
   logic [LEN_W-1:0] w_len;
   logic             w_cross;
   logic [2:0]       w_burst;
   logic             w_accept;
   logic             w_bad;
   logic             w_err1;
   logic             w_issue;
   logic             w_acc;
   logic             w_rd;
   logic             w_fail;
   logic             w_unused;
   function automatic logic [31:0] f_lane(input logic [31:0] d);
`ifdef AHB_MST_BSWAP_EN
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
      return d;
`endif
   endfunction
   assign w_unused = &{1'b0, bus.cmd_addr[1:0]};
   assign w_len = (bus.cmd_len == '0) ? LEN_W'(1) :
                  (bus.cmd_len > LEN_W'(MAX_BEATS)) ? LEN_W'(MAX_BEATS) : bus.cmd_len;
   // Last word index past 255 means the burst runs over a 1 KB page.
   assign w_cross = ({2'b00, bus.cmd_addr[9:2]} + 10'(w_len)) > 10'd256;
   assign w_burst = (w_len == LEN_W'(1)) ? 3'b000 :
                    w_cross ? 3'b001 :
                    (w_len == LEN_W'(4)) ? 3'b011 :
                    (w_len == LEN_W'(8)) ? 3'b101 :
                    (w_len == LEN_W'(16)) ? 3'b111 : 3'b001;
   assign w_accept = (r_state == S_IDLE) && bus.cmd_valid;
   // ERROR on the outstanding data phase cancels whatever address is being presented.
   assign w_bad   = r_dph && (bus.HRESP == 2'b01);
   assign w_err1  = w_bad && !bus.HREADY;
   assign w_issue = (r_state == S_ADDR || r_state == S_BURST) && (!r_write || bus.wr_valid) && !w_bad;
   assign w_acc   = w_issue && bus.HREADY;
   assign w_rd    = r_dph && bus.HREADY && (bus.HRESP == 2'b00) && !r_write;
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) r_state <= S_IDLE;
      else r_state <= w_nxt;
   always_comb begin
      w_nxt  = r_state;
      w_fail = 1'b0;
      case (r_state)
         S_IDLE: w_nxt = bus.cmd_valid ? S_ADDR : S_IDLE;
         S_ADDR, S_BURST, S_LAST:
            if (w_bad) begin
               w_nxt  = bus.HREADY ? S_DONE : S_ERR;
               w_fail = bus.HREADY;
            end else if (r_state == S_LAST)
               w_nxt = bus.HREADY ? S_DONE : S_LAST;
            else if (w_acc)
               w_nxt = (r_left == LEN_W'(1)) ? S_LAST : S_BURST;
         S_ERR: begin
            w_nxt  = bus.HREADY ? S_DONE : S_ERR;
            w_fail = bus.HREADY;
         end
         default: w_nxt = S_IDLE;
      endcase
   end
   always_comb begin
      // A beat landing on a 1 KB page start restarts the burst with NONSEQ; never BUSY into it.
      bus.HTRANS    = w_issue ? ((r_state == S_ADDR || r_addr[9:0] == 10'd0) ? T_NONSEQ : T_SEQ) :
                      (r_state == S_BURST && !w_bad && r_addr[9:0] != 10'd0) ? T_BUSY : T_IDLE;
      bus.wr_ready  = w_acc && r_write;
      bus.cmd_ready = r_state == S_IDLE;
      bus.done      = r_state == S_DONE;
      bus.err       = (r_state == S_DONE) && r_err;
      bus.rd_valid  = r_rd_valid;
      bus.rd_data   = r_rd_data;
      bus.HADDR     = r_addr;
      bus.HWRITE    = r_write;
      bus.HSIZE     = 3'b010;
      bus.HBURST    = r_burst;
      bus.HWDATA    = r_hwdata;
   end
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_addr     <= '0;
         r_left     <= '0;
         r_write    <= 1'b0;
         r_burst    <= 3'b000;
         r_dph      <= 1'b0;
         r_hwdata   <= '0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr  <= {bus.cmd_addr[31:2], 2'b00};
            r_left  <= w_len;
            r_write <= bus.cmd_write;
            r_burst <= w_burst;
            r_err   <= 1'b0;
         end else if (w_acc) begin
            r_addr <= r_addr + 32'd4;
            r_left <= r_left - LEN_W'(1);
         end
         if (w_fail) r_err <= 1'b1;
         if (bus.HREADY) r_dph <= w_acc;
         if (w_acc && r_write) r_hwdata <= f_lane(bus.wr_data);
         r_rd_valid <= w_rd;
         if (w_rd) r_rd_data <= f_lane(bus.HRDATA);
      end
   end
endmodule

// File: tb/tb_ahb_burst_master.sv
// tb_ahb_burst_master: directed scenarios for ahb_burst_master with hand-computed expectations
module tb_ahb_burst_master;
   logic HCLK = 1'b0;
   logic HRESETn = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;
   ahb_burst_master_if #(.LEN_W(5)) bus ();
   ahb_burst_master #(.MAX_BEATS(16), .LEN_W(5)) dut (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus.master));
   always #5 HCLK = ~HCLK;
   function automatic logic [31:0] exp_lane(input logic [31:0] d);
`ifdef AHB_MST_BSWAP_EN
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
      return d;
`endif
   endfunction
   task automatic step();
      @(posedge HCLK);
      #1;
   endtask
   task automatic send(input logic w, input logic [31:0] a, input logic [4:0] l);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_len   = l;
      step();
      bus.cmd_valid = 1'b0;
   endtask
   task automatic test_reset();
      n_vec++;
      if ({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.done, bus.err} !== 5'b10000) begin
         n_bad++;
         $display("FAIL reset_flags: got %b want 10000", {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.done, bus.err});
      end
      n_vec++;
      if ({bus.HTRANS, bus.HWRITE, bus.HSIZE, bus.HBURST} !== 9'b00_0_010_000) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b want 000010000", {bus.HTRANS, bus.HWRITE, bus.HSIZE, bus.HBURST});
      end
      n_vec++;
      if ({bus.HADDR, bus.HWDATA} !== 64'd0) begin
         n_bad++;
         $display("FAIL reset_data: got %h/%h want 0/0", bus.HADDR, bus.HWDATA);
      end
   endtask
   task automatic test_write_single();
      bus.wr_valid = 1'b1;
      bus.wr_data  = 32'hA1B2C3D4;
      send(1'b1, 32'h100, 5'd1);
      @(negedge HCLK);
      n_vec++;
      if ({bus.HTRANS, bus.HBURST, bus.HWRITE, bus.HADDR, bus.wr_ready} !== {2'b10, 3'b000, 1'b1, 32'h100, 1'b1}) begin
         n_bad++;
         $display("FAIL single_addr: got %b/%b/%b/%h/%b want 10/000/1/00000100/1",
                  bus.HTRANS, bus.HBURST, bus.HWRITE, bus.HADDR, bus.wr_ready);
      end
      step();
      bus.wr_valid = 1'b0;
      @(negedge HCLK);
      n_vec++;
      if (bus.HWDATA !== exp_lane(32'hA1B2C3D4) || bus.HTRANS !== 2'b00 || bus.done !== 1'b0) begin
         n_bad++;
         $display("FAIL single_data: got %h/%b/%b want %h/00/0", bus.HWDATA, bus.HTRANS, bus.done, exp_lane(32'hA1B2C3D4));
      end
      step();
      @(negedge HCLK);
      n_vec++;
      if ({bus.done, bus.err, bus.cmd_ready} !== 3'b100) begin
         n_bad++;
         $display("FAIL single_done: got done/err/cmd_ready %b want 100", {bus.done, bus.err, bus.cmd_ready});
      end
      step();
      @(negedge HCLK);
      n_vec++;
      if ({bus.done, bus.cmd_ready} !== 2'b01) begin
         n_bad++;
         $display("FAIL single_idle: got done/cmd_ready %b want 01", {bus.done, bus.cmd_ready});
      end
      step();
   endtask
   task automatic test_read_incr4();
      logic [0:6]  rdy  = 7'b1101111;
      logic [31:0] rdat [0:6] = '{32'd0, 32'd1, 32'd0, 32'd2, 32'd3, 32'd4, 32'd0};
      logic [1:0]  tr   [0:6] = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
      logic [31:0] ad   [0:6] = '{32'h200, 32'h204, 32'h208, 32'h208, 32'h20C, 32'h0, 32'h0};
      logic [0:6]  rv   = 7'b0010111;
      logic [31:0] rd   [0:6] = '{32'd0, 32'd0, 32'd1, 32'd0, 32'd2, 32'd3, 32'd4};
      logic [0:6]  dn   = 7'b0000001;
      bus.wr_valid = 1'b0;
      send(1'b0, 32'h200, 5'd4);
      for (int i = 0; i < 7; i++) begin
         bus.HREADY = rdy[i];
         bus.HRDATA = rdat[i];
         @(negedge HCLK);
         if (i == 0) begin
            n_vec++;
            if (bus.HBURST !== 3'b011) begin
               n_bad++;
               $display("FAIL incr4_hburst: got %b want 011", bus.HBURST);
            end
         end
         n_vec++;
         if (bus.HTRANS !== tr[i] || (tr[i] != 2'b00 && bus.HADDR !== ad[i])) begin
            n_bad++;
            $display("FAIL incr4_addr cyc %0d: got %b @%h want %b @%h", i, bus.HTRANS, bus.HADDR, tr[i], ad[i]);
         end
         n_vec++;
         if (bus.rd_valid !== rv[i] || (rv[i] && bus.rd_data !== exp_lane(rd[i]))) begin
            n_bad++;
            $display("FAIL incr4_rd cyc %0d: got %b/%h want %b/%h", i, bus.rd_valid, bus.rd_data, rv[i], exp_lane(rd[i]));
         end
         n_vec++;
         if (bus.done !== dn[i]) begin
            n_bad++;
            $display("FAIL incr4_done cyc %0d: got %b want %b", i, bus.done, dn[i]);
         end
         step();
      end
      bus.HREADY = 1'b1;
   endtask
   task automatic test_write_busy();
      logic [0:6]  wv   = 7'b1001100;
      logic [31:0] wdat [0:6] = '{32'h3000, 32'h3004, 32'h3004, 32'h3004, 32'h3008, 32'h0, 32'h0};
      logic [1:0]  tr   [0:6] = '{2'd2, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 2'd0};
      logic [31:0] ad   [0:6] = '{32'h300, 32'h304, 32'h304, 32'h304, 32'h308, 32'h0, 32'h0};
      logic [0:6]  hwc  = 7'b0100110;
      logic [31:0] hwv  [0:6] = '{32'h0, 32'h3000, 32'h0, 32'h0, 32'h3004, 32'h3008, 32'h0};
      logic [0:6]  dn   = 7'b0000001;
      int          nw   = 0;
      send(1'b1, 32'h300, 5'd3);
      for (int i = 0; i < 7; i++) begin
         bus.wr_valid = wv[i];
         bus.wr_data  = wdat[i];
         @(negedge HCLK);
         if (bus.wr_ready === 1'b1) nw++;
         n_vec++;
         if (bus.HTRANS !== tr[i] || (tr[i] != 2'b00 && bus.HADDR !== ad[i]) || bus.wr_ready !== wv[i]) begin
            n_bad++;
            $display("FAIL busy_addr cyc %0d: got %b @%h wr_ready %b want %b @%h wr_ready %b",
                     i, bus.HTRANS, bus.HADDR, bus.wr_ready, tr[i], ad[i], wv[i]);
         end
         if (hwc[i]) begin
            n_vec++;
            if (bus.HWDATA !== exp_lane(hwv[i])) begin
               n_bad++;
               $display("FAIL busy_hwdata cyc %0d: got %h want %h", i, bus.HWDATA, exp_lane(hwv[i]));
            end
         end
         n_vec++;
         if (bus.done !== dn[i]) begin
            n_bad++;
            $display("FAIL busy_done cyc %0d: got %b want %b", i, bus.done, dn[i]);
         end
         step();
      end
      bus.wr_valid = 1'b0;
      n_vec++;
      if (nw != 3) begin
         n_bad++;
         $display("FAIL busy_wr_ready_count: got %0d want 3", nw);
      end
   endtask
   task automatic test_read_1k();
      logic [1:0]  tr [0:5] = '{2'd2, 2'd3, 2'd2, 2'd3, 2'd0, 2'd0};
      logic [31:0] ad [0:5] = '{32'h3F8, 32'h3FC, 32'h400, 32'h404, 32'h0, 32'h0};
      logic [0:5]  dn = 6'b000001;
      send(1'b0, 32'h3F8, 5'd4);
      for (int i = 0; i < 6; i++) begin
         @(negedge HCLK);
         if (i == 0) begin
            n_vec++;
            if (bus.HBURST !== 3'b001) begin
               n_bad++;
               $display("FAIL k1_hburst: got %b want 001", bus.HBURST);
            end
         end
         n_vec++;
         if (bus.HTRANS !== tr[i] || (tr[i] != 2'b00 && bus.HADDR !== ad[i]) || bus.done !== dn[i]) begin
            n_bad++;
            $display("FAIL k1_beat cyc %0d: got %b @%h done %b want %b @%h done %b",
                     i, bus.HTRANS, bus.HADDR, bus.done, tr[i], ad[i], dn[i]);
         end
         step();
      end
   endtask
   task automatic test_write_error();
      logic [0:6]  rdy = 7'b1110111;
      logic [0:6]  eb  = 7'b0001100;
      logic [1:0]  tr [0:6] = '{2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
      logic [31:0] ad [0:6] = '{32'h500, 32'h504, 32'h508, 32'h0, 32'h0, 32'h0, 32'h0};
      logic [0:6]  wrr = 7'b1110000;
      logic [0:6]  de  = 7'b0000010;
      int          nw  = 0;
      bus.wr_valid = 1'b1;
      bus.wr_data  = 32'h5555AAAA;
      send(1'b1, 32'h500, 5'd5);
      // Error hits the data phase of beat 2 (counting from 0), the one at 0x508.
      for (int i = 0; i < 7; i++) begin
         bus.HREADY = rdy[i];
         bus.HRESP  = {1'b0, eb[i]};
         @(negedge HCLK);
         if (bus.wr_ready === 1'b1) nw++;
         n_vec++;
         if (bus.HTRANS !== tr[i] || (tr[i] != 2'b00 && bus.HADDR !== ad[i]) || bus.wr_ready !== wrr[i]) begin
            n_bad++;
            $display("FAIL err_beat cyc %0d: got %b @%h wr_ready %b want %b @%h wr_ready %b",
                     i, bus.HTRANS, bus.HADDR, bus.wr_ready, tr[i], ad[i], wrr[i]);
         end
         n_vec++;
         if ({bus.done, bus.err} !== {de[i], de[i]}) begin
            n_bad++;
            $display("FAIL err_status cyc %0d: got done/err %b%b want %b%b", i, bus.done, bus.err, de[i], de[i]);
         end
         step();
      end
      bus.HREADY   = 1'b1;
      bus.HRESP    = 2'b00;
      bus.wr_valid = 1'b0;
      n_vec++;
      if (nw != 3 || bus.cmd_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL err_wr_ready_count: got %0d cmd_ready %b want 3 cmd_ready 1", nw, bus.cmd_ready);
      end
   endtask
   task automatic test_len_clamp();
      int   beats = 0;
      logic seen  = 1'b0;
      send(1'b0, 32'h13, 5'd0);
      @(negedge HCLK);
      n_vec++;
      if ({bus.HTRANS, bus.HBURST, bus.HADDR} !== {2'b10, 3'b000, 32'h10}) begin
         n_bad++;
         $display("FAIL len0_addr: got %b/%b/%h want 10/000/00000010", bus.HTRANS, bus.HBURST, bus.HADDR);
      end
      step();
      @(negedge HCLK);
      n_vec++;
      if (bus.HTRANS !== 2'b00) begin
         n_bad++;
         $display("FAIL len0_last: got %b want 00", bus.HTRANS);
      end
      step();
      @(negedge HCLK);
      n_vec++;
      if ({bus.done, bus.err} !== 2'b10) begin
         n_bad++;
         $display("FAIL len0_done: got %b want 10", {bus.done, bus.err});
      end
      step();
      send(1'b0, 32'h0, 5'd20);
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge HCLK);
         if (i == 0) begin
            n_vec++;
            if (bus.HBURST !== 3'b111) begin
               n_bad++;
               $display("FAIL clamp_hburst: got %b want 111", bus.HBURST);
            end
         end
         if (bus.HTRANS[1] === 1'b1) beats++;
         seen = bus.done;
         step();
      end
      n_vec++;
      if (!seen) begin
         n_bad++;
         $display("FAIL clamp_done: got no done within 40 cycles want done");
      end
      n_vec++;
      if (beats != 16) begin
         n_bad++;
         $display("FAIL clamp_beats: got %0d want 16", beats);
      end
   endtask
   task automatic test_reset_mid();
      send(1'b0, 32'h600, 5'd8);
      step();
      step();
      @(negedge HCLK);
      HRESETn = 1'b0;
      #1;
      n_vec++;
      if ({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.done, bus.err, bus.HTRANS, bus.HWRITE, bus.HSIZE, bus.HBURST}
          !== 14'b10000_00_0_010_000) begin
         n_bad++;
         $display("FAIL mid_reset_ctrl: got %b want 10000000010000",
                  {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.done, bus.err, bus.HTRANS, bus.HWRITE, bus.HSIZE, bus.HBURST});
      end
      n_vec++;
      if ({bus.HADDR, bus.HWDATA} !== 64'd0) begin
         n_bad++;
         $display("FAIL mid_reset_data: got %h/%h want 0/0", bus.HADDR, bus.HWDATA);
      end
      step();
      @(negedge HCLK);
      HRESETn = 1'b1;
      step();
      bus.wr_valid = 1'b1;
      bus.wr_data  = 32'h11223344;
      send(1'b1, 32'h0, 5'd1);
      @(negedge HCLK);
      n_vec++;
      if ({bus.HTRANS, bus.HWRITE, bus.HADDR} !== {2'b10, 1'b1, 32'h0}) begin
         n_bad++;
         $display("FAIL post_reset_addr: got %b/%b/%h want 10/1/00000000", bus.HTRANS, bus.HWRITE, bus.HADDR);
      end
      step();
      bus.wr_valid = 1'b0;
      @(negedge HCLK);
      n_vec++;
      if (bus.HWDATA !== exp_lane(32'h11223344)) begin
         n_bad++;
         $display("FAIL post_reset_hwdata: got %h want %h", bus.HWDATA, exp_lane(32'h11223344));
      end
      step();
      @(negedge HCLK);
      n_vec++;
      if ({bus.done, bus.err} !== 2'b10) begin
         n_bad++;
         $display("FAIL post_reset_done: got %b want 10", {bus.done, bus.err});
      end
      step();
   endtask
   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_len   = '0;
      bus.wr_valid  = 1'b0;
      bus.wr_data   = '0;
      bus.HREADY    = 1'b1;
      bus.HRESP     = 2'b00;
      bus.HRDATA    = '0;
      #1 HRESETn = 1'b0;
      #1 test_reset();
      step();
      step();
      HRESETn = 1'b1;
      step();
      test_write_single();
      test_read_incr4();
      test_write_busy();
      test_read_1k();
      test_write_error();
      test_len_clamp();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
